regfile_mp_sb: RTL and testbench

//  Parametrised multi-port register file with write-to-read bypass and a per-register

---
 rtl/regfile_pkg.sv | 29 ++
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/regfile_mp_sb.sv | 86 ++++++++
 tb/tb_regfile_mp_sb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file with scoreboard.
package regfile_pkg;

    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned DEPTH_DEF = 32;
    localparam int unsigned NR_DEF    = 2;
    localparam int unsigned NW_DEF    = 1;
    localparam int unsigned ZERO_REG  = 0;
    localparam int unsigned POP_MAX   = 1024;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < POP_MAX; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracking: issue sets, write clears, flush clears all.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH = DEPTH_DEF,
    parameter  int unsigned NR    = NR_DEF,
    parameter  int unsigned NW    = NW_DEF,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NW-1:0]    wr_en,
    input  logic [NW*AW-1:0] wr_addr,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             flush,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR-1:0]    rd_pending,
    output logic [AW:0]      busy_cnt
);

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pend_nxt;

    // Priority by assignment order: write clear, then issue set, then flush.
    always_comb begin
        pend_nxt = pending;
        for (int unsigned j = 0; j < NW; j++) begin
            if (wr_en[j]) pend_nxt[wr_addr[j*AW +: AW]] = 1'b0;
        end
        if (iss_en && iss_addr != AW'(ZERO_REG)) pend_nxt[iss_addr] = 1'b1;
        if (flush) pend_nxt = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= '0;
            busy_cnt <= '0;
        end else begin
            pending  <= pend_nxt;
            busy_cnt <= (AW+1)'(popcount(POP_MAX'(pend_nxt)));
        end
    end

    always_comb begin
        rd_pending = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            rd_pending[i] = pending[rd_addr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass and operand-ready flags.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter  int unsigned DW    = DW_DEF,
    parameter  int unsigned DEPTH = DEPTH_DEF,
    parameter  int unsigned NR    = NR_DEF,
    parameter  int unsigned NW    = NW_DEF,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NR*AW-1:0] rd_addr,
    output logic [NR*DW-1:0] rd_data,
    output logic [NR-1:0]    rd_ready,
    input  logic [NW-1:0]    wr_en,
    input  logic [NW*AW-1:0] wr_addr,
    input  logic [NW*DW-1:0] wr_data,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic             flush,
    output logic [AW:0]      busy_cnt
);

    logic [DW-1:0] regs [DEPTH];
    logic [NR-1:0] rd_pending;

    regfile_scoreboard #(
        .DEPTH (DEPTH),
        .NR    (NR),
        .NW    (NW)
    ) u_sb (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .flush      (flush),
        .rd_addr    (rd_addr),
        .rd_pending (rd_pending),
        .busy_cnt   (busy_cnt)
    );

    // Later ports are assigned last, so the highest index wins on equal dest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
        end else begin
            for (int unsigned j = 0; j < NW; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] != AW'(ZERO_REG))
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
            end
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        logic          hit;
        logic [DW-1:0] bdata;
        rd_data  = '0;
        rd_ready = '1;
        for (int unsigned i = 0; i < NR; i++) begin
            a     = rd_addr[i*AW +: AW];
            hit   = 1'b0;
            bdata = '0;
            for (int unsigned j = 0; j < NW; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
                    hit   = 1'b1;
                    bdata = wr_data[j*DW +: DW];
                end
            end
            if (!reset_n || a == AW'(ZERO_REG)) begin
                rd_data[i*DW +: DW] = '0;
                rd_ready[i]         = 1'b1;
            end else if (hit) begin
                rd_data[i*DW +: DW] = bdata;
                rd_ready[i]         = 1'b1;
            end else begin
                rd_data[i*DW +: DW] = regs[a];
                rd_ready[i]         = ~rd_pending[i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed vector table, reset corner sequence and a randomized model comparison.
module tb_regfile_mp_sb;

    localparam int unsigned DW = 32, DEPTH = 32, NR = 2, NW = 2, AW = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_ready;
    logic [NW-1:0]    wr_en = '0;
    logic [NW*AW-1:0] wr_addr = '0;
    logic [NW*DW-1:0] wr_data = '0;
    logic             iss_en = 1'b0;
    logic [AW-1:0]    iss_addr = '0;
    logic             flush = 1'b0;
    logic [AW:0]      busy_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_mp_sb #(.DW(DW), .DEPTH(DEPTH), .NR(NR), .NW(NW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        iss;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0, ra1;
        logic [31:0] d0, d1;
        logic        r0, r1;
        logic [5:0]  busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                                logic [4:0] wa1, logic [31:0] wd1, logic iss,
                                logic [4:0] ia, logic fl, logic [4:0] ra0, logic [4:0] ra1,
                                logic [31:0] d0, logic r0, logic [31:0] d1, logic r1,
                                logic [5:0] busy);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.iss = iss; v.ia = ia; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
        v.d0 = d0; v.r0 = r0; v.d1 = d1; v.r1 = r1; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] d0, input logic r0,
                              input logic [31:0] d1, input logic r1, input logic [5:0] busy);
        chk({tag, " d0"}, 64'(rd_data[31:0]), 64'(d0));
        chk({tag, " r0"}, 64'(rd_ready[0]), 64'(r0));
        chk({tag, " d1"}, 64'(rd_data[63:32]), 64'(d1));
        chk({tag, " r1"}, 64'(rd_ready[1]), 64'(r1));
        chk({tag, " busy"}, 64'(busy_cnt), 64'(busy));
    endtask

    task automatic idle_inputs();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    // reference model for the random phase
    logic [31:0] m_regs [DEPTH];
    logic        m_pend [DEPTH];

    initial begin
        // table: row = write/issue/flush inputs, read addrs, expected pre-edge outputs
        vecs.push_back(mk(2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 6, 32'hDEADBEEF, 1, 0, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 1, 0, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 7, 0, 7, 5, 0, 1, 32'hDEADBEEF, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 7, 0, 0, 0, 0, 1));
        vecs.push_back(mk(2'b01, 7, 32'h11, 0, 0, 0, 0, 0, 7, 5, 32'h11, 1, 32'hDEADBEEF, 1, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 3, 32'h11, 1, 0, 1, 0));
        vecs.push_back(mk(2'b10, 0, 0, 3, 32'h22, 1, 3, 0, 3, 7, 32'h22, 1, 32'h11, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 3, 32'h22, 0, 32'h22, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 4, 1, 4, 3, 0, 1, 32'h22, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 4, 3, 0, 1, 32'h22, 1, 0));
        vecs.push_back(mk(2'b11, 9, 32'hA, 9, 32'hB, 0, 0, 0, 9, 9, 32'hB, 1, 32'hB, 1, 0));
        vecs.push_back(mk(2'b01, 0, 32'hFFFF, 0, 0, 0, 0, 0, 0, 9, 0, 1, 32'hB, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 1, 32'hB, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 32'hB, 1, 32'hB, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 32'hB, 0, 32'hB, 0, 1));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 1, 10, 0, 9, 10, 32'hB, 0, 0, 1, 1));
        vecs.push_back(mk(2'b11, 9, 32'h99, 10, 32'h1010, 0, 0, 0, 9, 10, 32'h99, 1, 32'h1010, 1, 2));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 10, 32'h99, 1, 32'h1010, 1, 0));
        vecs.push_back(mk(2'b11, 12, 32'h5, 12, 32'h6, 1, 0, 0, 12, 0, 32'h6, 1, 0, 1, 0));
        vecs.push_back(mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 12, 0, 32'h6, 1, 0, 1, 0));

        // power-on reset
        #1 reset_n = 1'b0;
        rd_addr = {5'd5, 5'd9};
        #2 check_outs("por", 0, 1, 0, 1, 0);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            wr_en    = vecs[k].we;
            wr_addr  = {vecs[k].wa1, vecs[k].wa0};
            wr_data  = {vecs[k].wd1, vecs[k].wd0};
            iss_en   = vecs[k].iss;
            iss_addr = vecs[k].ia;
            flush    = vecs[k].fl;
            rd_addr  = {vecs[k].ra1, vecs[k].ra0};
            #1 check_outs($sformatf("vec%0d", k), vecs[k].d0, vecs[k].r0,
                          vecs[k].d1, vecs[k].r1, vecs[k].busy);
        end

        // reset mid-operation: pending and in-flight write must vanish
        @(negedge clk);
        idle_inputs();
        iss_en = 1'b1; iss_addr = 5'd20;
        wr_en = 2'b01; wr_addr = {5'd0, 5'd21}; wr_data = {32'h0, 32'h2121};
        @(negedge clk);
        idle_inputs();
        rd_addr = {5'd21, 5'd20};
        #1 check_outs("pre_rst", 0, 0, 32'h2121, 1, 1);
        @(negedge clk);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd22}; wr_data = {32'h0, 32'h77};
        rd_addr = {5'd22, 5'd21};
        #2 reset_n = 1'b0;
        #1 check_outs("in_rst", 0, 1, 0, 1, 0);
        @(posedge clk);
        #1 check_outs("rst_edge", 0, 1, 0, 1, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle_inputs();
        #1 check_outs("post_rst", 0, 1, 0, 1, 0);
        rd_addr = {5'd20, 5'd5};
        #1 check_outs("post_rst_r5", 0, 1, 0, 1, 0);

        // randomized traffic against a behavioural model
        for (int r = 0; r < DEPTH; r++) begin
            m_regs[r] = '0;
            m_pend[r] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] ed [2];
            logic        er [2];
            int          cnt;
            @(negedge clk);
            wr_en    = 2'($urandom_range(0, 3));
            wr_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wr_data  = {$urandom, $urandom};
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = 5'($urandom_range(0, 7));
            flush    = ($urandom_range(0, 31) == 0);
            rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            for (int i = 0; i < 2; i++) begin
                logic [4:0] a;
                a = rd_addr[i*5 +: 5];
                ed[i] = m_regs[a];
                er[i] = !m_pend[a];
                for (int j = 0; j < 2; j++) begin
                    if (wr_en[j] && wr_addr[j*5 +: 5] == a) begin
                        ed[i] = wr_data[j*32 +: 32];
                        er[i] = 1'b1;
                    end
                end
                if (a == 0) begin
                    ed[i] = '0;
                    er[i] = 1'b1;
                end
            end
            cnt = 0;
            for (int r = 0; r < DEPTH; r++) if (m_pend[r]) cnt++;
            #1 check_outs($sformatf("rnd%0d", c), ed[0], er[0], ed[1], er[1], 6'(cnt));
            @(posedge clk);
            for (int j = 0; j < 2; j++) begin
                if (wr_en[j]) begin
                    if (wr_addr[j*5 +: 5] != 0) m_regs[wr_addr[j*5 +: 5]] = wr_data[j*32 +: 32];
                    m_pend[wr_addr[j*5 +: 5]] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1'b1;
            if (flush) for (int r = 0; r < DEPTH; r++) m_pend[r] = 1'b0;
        end

        @(negedge clk);
        idle_inputs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
